// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   tx_state_t      - transmitter FSM states
//   UART_DATA_BITS  - payload bits per frame
//   UART_IDLE_LEVEL - line level between frames and during stop bits
//   baud_div()      - clock cycles per bit for a given clock and line rate
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB wrap pointers.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset (clears pointers)
//   push, wdata  - write strobe and data (ignored when full)
//   pop, rdata   - read strobe (ignored when empty); rdata shows the head entry
//   level        - number of stored entries
//   full, empty  - status flags decoded from the pointers
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // Full when the pointers sit on the same slot but on different laps
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered 8N1/8N2 UART transmitter, LSB first, frames sent back-to-back.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset (abandons any frame in flight)
//   in_valid     - byte offered
//   in_data      - byte to send, sampled only on an accepted transfer
//   in_ready     - registered, high whenever the FIFO is not full
//   uart_tx      - registered serial line, idle high
//   busy         - registered, frame in progress or bytes still queued
//   fifo_level   - bytes queued and not yet popped
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUDRATE   = 25000000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV   = baud_div(CLK_HZ, BAUDRATE);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_buf: CLK_HZ/BAUDRATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_buf: STOP_BITS must be 1 or 2");
  end

  tx_state_t                 state;
  logic [CNT_W-1:0]          baud_cnt;
  logic [BIT_W-1:0]          bit_idx;
  logic                      stop_idx;
  logic [UART_DATA_BITS-1:0] shreg;

  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;

  logic                      push_c;
  logic                      pop_c;
  logic                      bit_done_c;
  logic                      last_stop_c;
  logic                      idle_next_c;
  logic [LVL_W-1:0]          level_next_c;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_c),
    .wdata  (in_data),
    .pop    (pop_c),
    .rdata  (fifo_rdata),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign push_c = in_valid && in_ready;

  // Pop decision and "FSM heads to IDLE" flag for the coming edge
  always_comb begin
    bit_done_c  = (baud_cnt == '0);
    last_stop_c = bit_done_c && (stop_idx == 1'(STOP_BITS - 1));
    pop_c       = 1'b0;
    idle_next_c = 1'b0;
    case (state)
      IDLE: begin
        pop_c       = !fifo_empty;
        idle_next_c = fifo_empty;
      end
      STOP: begin
        pop_c       = last_stop_c && !fifo_empty;
        idle_next_c = last_stop_c && fifo_empty;
      end
      default: ;
    endcase
  end

  // Occupancy after this edge; lets in_ready and busy be registered without lag
  assign level_next_c = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);

  // Transmit FSM with baud counter, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      uart_tx  <= UART_IDLE_LEVEL;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
    end else begin
      in_ready <= (level_next_c != LVL_W'(FIFO_DEPTH));
      busy     <= !idle_next_c || (level_next_c != '0);
      case (state)
        IDLE: begin
          uart_tx <= UART_IDLE_LEVEL;
          if (pop_c) begin
            shreg    <= fifo_rdata;
            baud_cnt <= CNT_W'(DIV - 1);
            state    <= START;
            uart_tx  <= 1'b0;
          end
        end
        START: begin
          if (bit_done_c) begin
            state    <= DATA;
            uart_tx  <= shreg[0];
            bit_idx  <= '0;
            baud_cnt <= CNT_W'(DIV - 1);
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done_c) begin
            shreg    <= {1'b0, shreg[UART_DATA_BITS-1:1]};
            baud_cnt <= CNT_W'(DIV - 1);
            if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
              state    <= STOP;
              uart_tx  <= UART_IDLE_LEVEL;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              uart_tx <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done_c) begin
            baud_cnt <= CNT_W'(DIV - 1);
            if (last_stop_c) begin
              // Next byte's start bit follows the stop bit with no idle cycle
              if (pop_c) begin
                shreg   <= fifo_rdata;
                state   <= START;
                uart_tx <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
